// File: rtl/repeat_range_sum_pkg.sv
// repeat_range_sum_pkg
//   Shared definitions for the repeat_range_sum engine:
//   - default widths (data path, accumulator) and the largest digit count
//   - FSM state encodings for the engine controller
//   - pow10 helper used to build block bounds and the repeat multiplier
package repeat_range_sum_pkg;

  // Default data width must satisfy 10^MAX_DIGITS-1 < 2^DATA_W.
  localparam int DEFAULT_DATA_W     = 40;
  localparam int DEFAULT_SUM_W      = 64;
  localparam int DEFAULT_MAX_DIGITS = 10;

  // Width of the pow10 result; 10^38 is the largest power that fits.
  localparam int POW10_W   = 128;
  localparam int POW10_MAX = 38;

  // Engine controller states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_MBUILD = 3'd2;
  localparam logic [2:0] ST_DIV_LO = 3'd3;
  localparam logic [2:0] ST_DIV_HI = 3'd4;
  localparam logic [2:0] ST_ACCUM  = 3'd5;
  localparam logic [2:0] ST_NEXT   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  // 10^n as a wide constant-bounded loop; callers truncate to their width.
  // Exponents beyond POW10_MAX saturate at 10^POW10_MAX.
  function automatic logic [POW10_W-1:0] pow10(input logic [7:0] n);
    logic [POW10_W-1:0] r;
    r = POW10_W'(1);
    for (int i = 0; i < POW10_MAX; i++) begin
      if (i < int'(n)) begin
        r = r * POW10_W'(10);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/repeat_range_sum_serial_divider.sv
// repeat_range_sum_serial_divider
//   Restoring divider producing one quotient bit per clock.
//   A divide takes DATA_W+2 cycles as seen by the caller: the start cycle
//   (which already performs the first step), DATA_W further step cycles,
//   and one cycle with done high and the quotient valid.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a divide (sampled only when idle)
//   dividend     DATA_W+1-bit dividend
//   divisor      DATA_W-bit divisor, must be non-zero
//   busy         a divide is in progress
//   done         one-cycle pulse, quotient valid
//   quotient     DATA_W+1-bit quotient
module repeat_range_sum_serial_divider #(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W:0]   dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W:0]   quotient
);

  localparam int CW = $clog2(DATA_W + 2);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W:0]   quo_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] rem_src;
  logic [DATA_W:0]   quo_src;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W:0]   quo_nx;

  // One restoring step. The quotient register doubles as the dividend
  // shifter: its MSB feeds the partial remainder and the new quotient bit
  // enters at the LSB. On start the step works straight from the inputs.
  // The remainder stays below the divisor, so the low DATA_W bits of the
  // subtraction are exact whenever the trial value is large enough.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    trial   = {rem_src, quo_src[DATA_W]};
    ge      = (trial >= {1'b0, divisor});
    diff    = trial[DATA_W-1:0] - divisor;
    rem_nx  = ge ? diff : trial[DATA_W-1:0];
    quo_nx  = {quo_src[DATA_W-1:0], ge};
  end

  // Step sequencer: DATA_W+1 steps in total, done is raised for exactly
  // one cycle after the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      cnt_q  <= CW'(1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/repeat_range_sum.sv
// repeat_range_sum
//   Sums every N in [lo_in, hi_in] whose decimal form is a P-digit block
//   (no leading zero) repeated exactly reps_in times, for every P with
//   P*reps_in <= MAX_DIGITS. Such N equal block*M with
//   M = 1 + 10^P + ... + 10^((k-1)P), so for each P the matching blocks
//   form the contiguous range [max(10^(P-1), ceil(lo/M)),
//   min(10^P-1, floor(hi/M))] and their sum is an arithmetic series.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     request valid
//   in_ready     engine idle and accepting a request
//   lo_in        range low bound, inclusive
//   hi_in        range high bound, inclusive
//   reps_in      repetition count k
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   sum_out      sum of matching N, modulo 2^SUM_W
//   err_out      request was illegal (k<2 or k>MAX_DIGITS); sum_out is 0
module repeat_range_sum
  import repeat_range_sum_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int SUM_W      = DEFAULT_SUM_W,
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [3:0]        reps_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic              err_out
);

  logic [2:0]        state;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [3:0]        k_q;
  logic [7:0]        p_q;
  logic [DATA_W-1:0] m_q;
  logic [3:0]        mcnt;
  logic [DATA_W:0]   qlo_q;
  logic [DATA_W:0]   qhi_q;
  logic [SUM_W-1:0]  acc_q;
  logic              err_q;

  logic [DATA_W-1:0] pow_p;
  logic [DATA_W-1:0] pow_pm1;
  logic [DATA_W-1:0] m_next;
  logic [DATA_W:0]   blk_lo;
  logic [DATA_W:0]   blk_hi;
  logic [DATA_W:0]   a_v;
  logic [DATA_W:0]   b_v;
  logic [SUM_W-1:0]  sum_ab;
  logic [SUM_W-1:0]  cnt_ab;
  logic [SUM_W-1:0]  tri_sum;
  logic [SUM_W-1:0]  term;
  logic              k_legal;
  logic              last_block;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W:0]   div_dividend;
  logic [DATA_W:0]   div_quotient;

  // Per-P constants and the series arithmetic for the ACCUM step.
  // (a+b)*(b-a+1) is always even, so the halving shift is exact.
  always_comb begin
    pow_p   = DATA_W'(pow10(p_q));
    pow_pm1 = DATA_W'(pow10(p_q - 8'd1));
    m_next  = m_q * pow_p + DATA_W'(1);
    blk_lo  = {1'b0, pow_pm1};
    blk_hi  = {1'b0, pow_p - DATA_W'(1)};
    a_v     = (qlo_q > blk_lo) ? qlo_q : blk_lo;
    b_v     = (qhi_q < blk_hi) ? qhi_q : blk_hi;
    sum_ab  = SUM_W'(a_v) + SUM_W'(b_v);
    cnt_ab  = SUM_W'(b_v) - SUM_W'(a_v) + SUM_W'(1);
    tri_sum = (sum_ab * cnt_ab) >> 1;
    term    = SUM_W'(m_q) * tri_sum;
    k_legal = (k_q >= 4'd2) && (int'(k_q) <= MAX_DIGITS);
    last_block = ((int'(p_q) + 1) * int'(k_q)) > MAX_DIGITS;
  end

  // Divider sharing: the same unit computes ceil(lo/M) in DIV_LO and
  // floor(hi/M) in DIV_HI. A divide is launched on the first cycle of each
  // state, i.e. whenever the unit is neither running nor reporting done.
  always_comb begin
    div_start    = ((state == ST_DIV_LO) || (state == ST_DIV_HI)) &&
                   !div_busy && !div_done;
    div_dividend = (state == ST_DIV_LO) ?
                   ({1'b0, lo_q} + {1'b0, m_q} - (DATA_W+1)'(1)) :
                   {1'b0, hi_q};
  end

  repeat_range_sum_serial_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (m_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Controller and datapath registers. Each block length P runs
  // MBUILD -> DIV_LO -> DIV_HI -> ACCUM -> NEXT; NEXT stops before any P
  // whose k*P digits would exceed MAX_DIGITS, which keeps M inside DATA_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lo_q  <= '0;
      hi_q  <= '0;
      k_q   <= '0;
      p_q   <= '0;
      m_q   <= '0;
      mcnt  <= '0;
      qlo_q <= '0;
      qhi_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            lo_q  <= lo_in;
            hi_q  <= hi_in;
            k_q   <= reps_in;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          acc_q <= '0;
          p_q   <= 8'd1;
          m_q   <= DATA_W'(1);
          mcnt  <= '0;
          if (!k_legal) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else if (lo_q > hi_q) begin
            err_q <= 1'b0;
            state <= ST_DONE;
          end else begin
            err_q <= 1'b0;
            state <= ST_MBUILD;
          end
        end
        ST_MBUILD: begin
          m_q  <= m_next;
          mcnt <= mcnt + 4'd1;
          if (mcnt == (k_q - 4'd2)) begin
            state <= ST_DIV_LO;
          end
        end
        ST_DIV_LO: begin
          if (div_done) begin
            qlo_q <= div_quotient;
            state <= ST_DIV_HI;
          end
        end
        ST_DIV_HI: begin
          if (div_done) begin
            qhi_q <= div_quotient;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (a_v <= b_v) begin
            acc_q <= acc_q + term;
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          p_q   <= p_q + 8'd1;
          m_q   <= DATA_W'(1);
          mcnt  <= '0;
          state <= last_block ? ST_DONE : ST_MBUILD;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign sum_out   = acc_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_repeat_range_sum.sv
// tb_repeat_range_sum
//   Self-checking bench for repeat_range_sum: a table of directed vectors,
//   hand-written handshake/latency/reset sequences, and random ranges
//   checked against a string-based enumeration model.
module tb_repeat_range_sum;

  localparam int DW   = 40;
  localparam int SW   = 64;
  localparam int MAXD = 10;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] lo_in;
  logic [DW-1:0] hi_in;
  logic [3:0]    reps_in;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sum_out;
  logic          err_out;

  int n_cmp;
  int n_fail;
  int last_lat;

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [3:0]    k;
    logic [SW-1:0] sum;
    logic          err;
  } vec_t;

  vec_t vecs[14];

  repeat_range_sum #(
    .DATA_W     (DW),
    .SUM_W      (SW),
    .MAX_DIGITS (MAXD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lo_in     (lo_in),
    .hi_in     (hi_in),
    .reps_in   (reps_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: enumerate every N and test its decimal string
  // for a period of len/k characters.
  function automatic longint unsigned modelSum(longint unsigned lo,
                                               longint unsigned hi, int k);
    longint unsigned s;
    s = 0;
    if (k < 2 || k > MAXD || lo > hi) return 0;
    for (longint unsigned n = lo; n <= hi; n++) begin
      string str;
      int    len;
      int    p;
      bit    ok;
      str = $sformatf("%0d", n);
      len = str.len();
      if ((len % k) == 0 && len <= MAXD) begin
        p  = len / k;
        ok = 1'b1;
        for (int i = p; i < len; i++) begin
          if (str[i] != str[i-p]) ok = 1'b0;
        end
        if (ok) s += n;
      end
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [SW-1:0] act,
                             input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the result, optionally hold
  // out_ready low for 'hold' cycles while checking stability, then
  // complete the handshake and check the engine goes idle.
  task automatic applyStimulus(input string name, input logic [DW-1:0] lo,
                               input logic [DW-1:0] hi, input logic [3:0] k,
                               input logic [SW-1:0] exp_sum,
                               input logic exp_err, input int hold);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    lo_in    = lo;
    hi_in    = hi;
    reps_in  = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_lat = 0;
    while (!out_valid && last_lat < 3000) begin
      @(posedge clk); #1;
      last_lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: actual=no out_valid required=out_valid within 3000 cycles", name);
      return;
    end
    checkOutput({name, "_sum"}, sum_out, exp_sum);
    checkOutput({name, "_err"}, SW'(err_out), SW'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, "_hold_valid"}, SW'(out_valid), SW'(1));
      checkOutput({name, "_hold_sum"}, sum_out, exp_sum);
      checkOutput({name, "_hold_ready"}, SW'(in_ready), SW'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_released"}, SW'(out_valid), SW'(0));
    checkOutput({name, "_idle"}, SW'(in_ready), SW'(1));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    last_lat  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lo_in     = '0;
    hi_in     = '0;
    reps_in   = '0;

    vecs[0]  = '{40'd11,     40'd22,     4'd2,  64'd33,     1'b0};
    vecs[1]  = '{40'd1,      40'd9999,   4'd2,  64'd495900, 1'b0};
    vecs[2]  = '{40'd1,      40'd999,    4'd3,  64'd4995,   1'b0};
    vecs[3]  = '{40'd1,      40'd999,    4'd4,  64'd0,      1'b0};
    vecs[4]  = '{40'd123123, 40'd123123, 4'd2,  64'd123123, 1'b0};
    vecs[5]  = '{40'd123124, 40'd123124, 4'd2,  64'd0,      1'b0};
    vecs[6]  = '{40'd95,     40'd115,    4'd2,  64'd99,     1'b0};
    vecs[7]  = '{40'd500,    40'd100,    4'd2,  64'd0,      1'b0};
    vecs[8]  = '{40'd5,      40'd5000,   4'd1,  64'd0,      1'b1};
    vecs[9]  = '{40'd0,      40'd5000,   4'd0,  64'd0,      1'b1};
    vecs[10] = '{40'd0,      40'd5000,   4'd11, 64'd0,      1'b1};
    vecs[11] = '{40'd0,      40'hFF_FFFF_FFFF, 4'd10, 64'd49999999995, 1'b0};
    vecs[12] = '{40'd0,      40'hFF_FFFF_FFFF, 4'd5,  64'd495455045400, 1'b0};
    vecs[13] = '{40'd0,      40'd10,     4'd2,  64'd0,      1'b0};

    // Reset state, checked while reset is held
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", SW'(in_ready), SW'(1));
    checkOutput("reset_out_valid", SW'(out_valid), SW'(0));
    checkOutput("reset_sum", sum_out, SW'(0));
    checkOutput("reset_err", SW'(err_out), SW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi,
                    vecs[i].k, vecs[i].sum, vecs[i].err, 0);
    end

    // Latency: illegal k and empty range finish in 2 cycles counting the
    // accept cycle; a full k=2 run spends (k-1)+2*(DW+2)+2 per block length.
    applyStimulus("lat_err", 40'd1, 40'd9, 4'd1, 64'd0, 1'b1, 0);
    checkOutput("lat_err_cycles", SW'(last_lat + 1), SW'(2));
    applyStimulus("lat_empty", 40'd500, 40'd100, 4'd2, 64'd0, 1'b0, 0);
    checkOutput("lat_empty_cycles", SW'(last_lat + 1), SW'(2));
    applyStimulus("lat_k2", 40'd11, 40'd22, 4'd2, 64'd33, 1'b0, 0);
    checkOutput("lat_k2_cycles", SW'(last_lat + 1),
                SW'(2 + (MAXD / 2) * ((2 - 1) + 2 * (DW + 2) + 2)));

    // Output back-pressure: hold out_ready low for 5 cycles
    applyStimulus("hold", 40'd11, 40'd22, 4'd2, 64'd33, 1'b0, 5);

    // Reset during DIV_HI of the second block length (accumulator already 33)
    lo_in    = 40'd11;
    hi_in    = 40'd22;
    reps_in  = 4'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (141) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", SW'(in_ready), SW'(1));
    checkOutput("midreset_out_valid", SW'(out_valid), SW'(0));
    checkOutput("midreset_sum", sum_out, SW'(0));
    checkOutput("midreset_err", SW'(err_out), SW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("after_reset", 40'd1, 40'd9999, 4'd2, 64'd495900, 1'b0, 0);

    // Random ranges against the enumeration model
    for (int r = 0; r < 12; r++) begin
      longint unsigned lo_r;
      longint unsigned hi_r;
      int              k_r;
      lo_r = longint'($urandom_range(0, 150000));
      hi_r = lo_r + longint'($urandom_range(0, 1500));
      k_r  = int'($urandom_range(2, 6));
      applyStimulus($sformatf("rand%0d", r), DW'(lo_r), DW'(hi_r), 4'(k_r),
                    SW'(modelSum(lo_r, hi_r, k_r)), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
